// File: rtl/data_mem.sv
// Simple dual-port synchronous RAM for the frame buffer datapath.
// One write port, one registered read port, shared clock; active-low strobes and reset.
module data_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Read-first: the read samples the array before this edge's write lands.
    always_comb begin
        rd_data_d = rd_data_q;
        if (!rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_data_q <= rd_data_d;
            if (!wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem (DATA_WIDTH=16, ADDR_WIDTH=3).
module tb_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  wr_addr;
    logic [2:0]  rd_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    int vectors = 0;
    int errs    = 0;

    data_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always #10 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b0; wr_addr = a; wr_data = d; rd_en = 1'b1;
        cyc();
        wr_en = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        rd_en = 1'b0; rd_addr = a; wr_en = 1'b1;
        cyc();
        rd_en = 1'b1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        // 1) reset held two edges with a write presented
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        wr_addr = 3'd0; rd_addr = 3'd0; wr_data = 16'h0001;
        cyc();
        cyc();
        check("reset_rd_data", rd_data, 16'h0000);
        reset = 1'b1; wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            read_chk($sformatf("reset_mem%0d", i), 3'(i), 16'h0000);
        end

        // 2) write/readback
        write(3'd1, 16'h0002);
        write(3'd2, 16'h0003);
        write(3'd3, 16'h0004);
        read_chk("rd_addr1", 3'd1, 16'h0002);
        read_chk("rd_addr2", 3'd2, 16'h0003);
        read_chk("rd_addr3", 3'd3, 16'h0004);

        // 3) read hold with rd_en high and a changed address
        read_chk("hold_pre", 3'd2, 16'h0003);
        rd_en = 1'b1; rd_addr = 3'd3;
        cyc();
        cyc();
        check("hold", rd_data, 16'h0003);

        // 4) same-address collision is read-first
        write(3'd5, 16'hAAAA);
        wr_en = 1'b0; wr_addr = 3'd5; wr_data = 16'h5555;
        rd_en = 1'b0; rd_addr = 3'd5;
        cyc();
        wr_en = 1'b1; rd_en = 1'b1;
        check("collide_old", rd_data, 16'hAAAA);
        read_chk("collide_new", 3'd5, 16'h5555);

        // different addresses in one cycle are independent
        wr_en = 1'b0; wr_addr = 3'd6; wr_data = 16'h1234;
        rd_en = 1'b0; rd_addr = 3'd3;
        cyc();
        wr_en = 1'b1; rd_en = 1'b1;
        check("indep_rd", rd_data, 16'h0004);
        read_chk("indep_wr", 3'd6, 16'h1234);

        // 5) write disabled
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
        repeat (3) cyc();
        read_chk("wr_disabled", 3'd7, 16'h0000);

        // 6) fill, then mid-run reset with pending read and write
        for (int i = 0; i < 8; i++) begin
            write(3'(i), 16'h1000 + 16'(i));
        end
        read_chk("fill4", 3'd4, 16'h1004);
        read_chk("fill7", 3'd7, 16'h1007);
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'hBEEF;
        rd_en = 1'b0; rd_addr = 3'd7;
        cyc();
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        check("midreset_rd_data", rd_data, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            read_chk($sformatf("midreset_mem%0d", i), 3'(i), 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
